h80cpu_bus_arbiter: RTL and testbench
=====================================

# h80cpu_bus_arbiter

Two-to-N port arbiter that shares one h80cpu toggle-handshake bus target (memory or I/O block) between several requesters, e.g. the CPU core and a DMA/debug loader. Each requester port uses the same run/done toggle protocol as the target. The arbiter selects one pending requester round-robin, forwards its command to the target, and returns read data and completion. It sits between the requesters and `h80cpu_mem`/`h80cpu_io`.

## Interface
- NUM_REQ, 2, number of requester ports (2..4)
- ADDR_W, 16, bus address width
- DATA_W, 16, bus data width
- CMD_W, 3, bus command width (read_w/write_w/read_b/write_b encodings pass through unchanged)
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_run  in  NUM_REQ  per-port toggle; port i pending when req_run[i] != req_done[i]
- req_addr  in  NUM_REQ x ADDR_W  per-port address; stable while pending
- req_cmd  in  NUM_REQ x CMD_W  per-port command; stable while pending
- req_wr_data  in  NUM_REQ x DATA_W  per-port write data; stable while pending
- req_done  out  NUM_REQ  per-port completion toggle
- req_rd_data  out  NUM_REQ x DATA_W  per-port read data, valid when req_done[i] == req_run[i]
- tgt_run  out  1  target toggle
- tgt_addr  out  ADDR_W  latched address to target
- tgt_cmd  out  CMD_W  latched command to target
- tgt_wr_data  out  DATA_W  latched write data to target
- tgt_done  in  1  target completion toggle
- tgt_rd_data  in  DATA_W  target read data, valid when tgt_done == tgt_run
- grant  out  2  index of port owning the target (last owner while idle)
- busy  out  1  high in S_WAIT

## Operation
- Reset values: req_done all 0, req_rd_data all 0, tgt_run 0, tgt_addr/tgt_cmd/tgt_wr_data 0, grant 0, busy 0, last-grant pointer = NUM_REQ-1 (so port 0 wins first), state S_IDLE.
- pending[i] = req_run[i] ^ req_done[i]; tgt_pending = tgt_run ^ tgt_done.
- S_IDLE: if any pending[i], choose first pending index scanning last+1, last+2, … modulo NUM_REQ. Latch req_addr/req_cmd/req_wr_data of winner into tgt_*; toggle tgt_run; grant <= winner; -> S_WAIT. No pending: hold.
- S_WAIT: when tgt_pending == 0 (target has toggled tgt_done): req_rd_data[grant] <= tgt_rd_data (copied for every command; writes return whatever the target drives); toggle req_done[grant]; last <= grant; -> S_IDLE.
- Only the granted port's req_done/req_rd_data change; other ports hold.
- Round-robin: a port that was just served has lowest priority next arbitration; with all ports continuously pending, service order is 0,1,…,NUM_REQ-1,0,….
- Requester rule: port must not toggle req_run again until req_done matches. A second toggle while pending un-pends the port; if it is not yet granted it is simply not served; if already granted the transaction completes and req_done toggles (port then shows pending again — protocol violation, not checked).
- Request field changes after grant have no effect (fields latched at grant).
- Reset mid-transaction: arbiter returns to reset values immediately; target must share the same reset so tgt_done also returns to 0. In-flight transaction is abandoned, no completion toggle issued.

## Timing
- Request toggle sampled at posedge N (S_IDLE) -> tgt_run toggles at posedge N, visible after N.
- Target completion observed at posedge M (S_WAIT) -> req_done toggles and req_rd_data updates at posedge M.
- Earliest next grant at posedge M+1 (one idle cycle between transactions; no back-to-back issue).
- With an `h80cpu_mem` target completing one cycle after issue: request-to-completion = 3 edges (issue N, target N+1, return N+2); throughput one transaction per 3 cycles.
- Combinational paths: none from req_* to tgt_* or req_done; all outputs registered.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> all outputs 0, grant 0, busy 0 without a clock edge; deassert, toggle req_run[0] -> port 0 granted first.
- Single read: port 0 read_w addr 0x2000, target returns 0x1234 one cycle later -> tgt_addr 0x2000, tgt_cmd read_w, req_rd_data[0] = 0x1234, req_done[0] toggles 3 edges after request.
- Single write: port 1 write_b addr 0x2001 data 0x00AB -> tgt_wr_data 0x00AB, tgt_cmd write_b, req_done[1] toggles, req_done[0] unchanged.
- Contention: ports 0 and 1 toggle same cycle, both re-request immediately on completion for 6 transactions -> grant sequence 0,1,0,1,0,1; each completes with its own read data.
- Stability: port 0 changes req_addr 0x0010 -> 0x0020 one cycle after grant -> tgt_addr stays 0x0010 until completion.
- Reset mid-transaction: reset asserted in S_WAIT before tgt_done toggles -> no req_done toggle, state S_IDLE, subsequent request served normally.

Source files
------------

// File: rtl/h80cpu_bus_arbiter.sv
// rtl/h80cpu_bus_arbiter.sv - round-robin arbiter sharing one h80cpu toggle-handshake target
// between NUM_REQ requester ports; per-port fields are packed flat, port i at slice i.
module h80cpu_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int CMD_W   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_run,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*CMD_W-1:0]  req_cmd,
  input  logic [NUM_REQ*DATA_W-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ*DATA_W-1:0] req_rd_data,
  output logic                      tgt_run,
  output logic [ADDR_W-1:0]         tgt_addr,
  output logic [CMD_W-1:0]          tgt_cmd,
  output logic [DATA_W-1:0]         tgt_wr_data,
  input  logic                      tgt_done,
  input  logic [DATA_W-1:0]         tgt_rd_data,
  output logic [1:0]                grant,
  output logic                      busy
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state;
  logic [1:0]         last;
  logic [NUM_REQ-1:0] pending;
  logic               found;
  logic [1:0]         winner;
  logic [ADDR_W-1:0]  sel_addr;
  logic [CMD_W-1:0]   sel_cmd;
  logic [DATA_W-1:0]  sel_wr_data;
  int                 idx;

  assign pending = req_run ^ req_done;

  // Scan last+1, last+2, ... so the most recently served port ranks lowest.
  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && idx == i && pending[i]) begin
          found  = 1'b1;
          winner = 2'(i);
        end
      end
    end
  end

  always_comb begin
    sel_addr    = '0;
    sel_cmd     = '0;
    sel_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == 2'(i)) begin
        sel_addr    = req_addr[i*ADDR_W +: ADDR_W];
        sel_cmd     = req_cmd[i*CMD_W +: CMD_W];
        sel_wr_data = req_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      last        <= 2'(NUM_REQ - 1);
      req_done    <= '0;
      req_rd_data <= '0;
      tgt_run     <= 1'b0;
      tgt_addr    <= '0;
      tgt_cmd     <= '0;
      tgt_wr_data <= '0;
      grant       <= 2'd0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            tgt_addr    <= sel_addr;
            tgt_cmd     <= sel_cmd;
            tgt_wr_data <= sel_wr_data;
            tgt_run     <= ~tgt_run;
            grant       <= winner;
            busy        <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Read data is returned for every command, writes included.
          if (tgt_run == tgt_done) begin
            for (int i = 0; i < NUM_REQ; i++) begin
              if (grant == 2'(i)) begin
                req_rd_data[i*DATA_W +: DATA_W] <= tgt_rd_data;
                req_done[i]                     <= ~req_done[i];
              end
            end
            last  <= grant;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_h80cpu_bus_arbiter.sv
// tb/tb_h80cpu_bus_arbiter.sv - directed and randomized checks of h80cpu_bus_arbiter
// against a toggle-handshake target model and a round-robin reference model.
module tb_h80cpu_bus_arbiter;
  localparam int NREQ = 2;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int CW = 3;
  localparam logic [2:0] RD_W = 3'd0;
  localparam logic [2:0] WR_W = 3'd1;
  localparam logic [2:0] WR_B = 3'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0]    req_run = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*CW-1:0] req_cmd = '0;
  logic [NREQ*DW-1:0] req_wr_data = '0;
  logic [NREQ-1:0]    req_done;
  logic [NREQ*DW-1:0] req_rd_data;
  logic               tgt_run;
  logic [AW-1:0]      tgt_addr;
  logic [CW-1:0]      tgt_cmd;
  logic [DW-1:0]      tgt_wr_data;
  logic               tgt_done;
  logic [DW-1:0]      tgt_rd_data;
  logic [1:0]         grant;
  logic               busy;
  logic [DW-1:0]      resp_key = '0;
  int tgt_lat = 0;
  int tgt_cnt;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  h80cpu_bus_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .CMD_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_run(req_run), .req_addr(req_addr), .req_cmd(req_cmd), .req_wr_data(req_wr_data),
    .req_done(req_done), .req_rd_data(req_rd_data),
    .tgt_run(tgt_run), .tgt_addr(tgt_addr), .tgt_cmd(tgt_cmd), .tgt_wr_data(tgt_wr_data),
    .tgt_done(tgt_done), .tgt_rd_data(tgt_rd_data),
    .grant(grant), .busy(busy)
  );

  // Target: answers tgt_lat+1 edges after issue with data derived from the address.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_done    <= 1'b0;
      tgt_rd_data <= '0;
      tgt_cnt     <= 0;
    end else if (tgt_run != tgt_done) begin
      if (tgt_cnt >= tgt_lat) begin
        tgt_done    <= tgt_run;
        tgt_rd_data <= tgt_addr ^ resp_key;
        tgt_cnt     <= 0;
      end else begin
        tgt_cnt <= tgt_cnt + 1;
      end
    end
  end

  task automatic issue(input int p, input logic [AW-1:0] a, input logic [CW-1:0] c, input logic [DW-1:0] d);
    req_addr[p*AW +: AW]    = a;
    req_cmd[p*CW +: CW]     = c;
    req_wr_data[p*DW +: DW] = d;
    req_run[p]              = ~req_run[p];
  endtask

  task automatic wait_port(input int p, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (req_done[p] == req_run[p]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_all(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (req_done == req_run && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset   = 1'b1;
    req_run = '0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    total++; if (req_done !== '0) begin bad++; $display("FAIL reset_done got=%h want=0", req_done); end
    total++; if (req_rd_data !== '0) begin bad++; $display("FAIL reset_rd got=%h want=0", req_rd_data); end
    total++; if ({tgt_run, tgt_addr, tgt_cmd, tgt_wr_data} !== '0) begin bad++; $display("FAIL reset_tgt got=%h want=0", {tgt_run, tgt_addr, tgt_cmd, tgt_wr_data}); end
    total++; if ({grant, busy} !== 3'b000) begin bad++; $display("FAIL reset_grant_busy got=%b want=000", {grant, busy}); end
    @(negedge clk); #1;
    resp_key = 16'hA5A5;
    issue(1, 16'h1234, WR_W, 16'hBEEF);
    wait_port(1, 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL reset_pre_txn got=timeout want=done"); end
    #2;
    reset   = 1'b1;
    req_run = '0;
    #1;
    total++; if (req_done !== '0) begin bad++; $display("FAIL async_reset_done got=%h want=0", req_done); end
    total++; if (req_rd_data !== '0) begin bad++; $display("FAIL async_reset_rd got=%h want=0", req_rd_data); end
    total++; if ({tgt_run, tgt_addr, tgt_cmd, tgt_wr_data} !== '0) begin bad++; $display("FAIL async_reset_tgt got=%h want=0", {tgt_run, tgt_addr, tgt_cmd, tgt_wr_data}); end
    total++; if ({grant, busy} !== 3'b000) begin bad++; $display("FAIL async_reset_grant_busy got=%b want=000", {grant, busy}); end
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    issue(0, 16'h0040, RD_W, 16'h0);
    issue(1, 16'h0050, RD_W, 16'h0);
    @(negedge clk);
    total++; if (grant !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL first_grant got=%0d/%b want=0/1", grant, busy); end
    total++; if (tgt_addr !== 16'h0040) begin bad++; $display("FAIL first_addr got=%h want=0040", tgt_addr); end
    wait_all(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL first_drain got=timeout want=idle"); end
  endtask

  task automatic test_single_read();
    logic [NREQ-1:0] d0;
    logic t0;
    @(negedge clk); #1;
    resp_key = 16'h3234;
    tgt_lat  = 0;
    d0 = req_done;
    t0 = tgt_run;
    issue(0, 16'h2000, RD_W, 16'h0);
    @(negedge clk);
    total++; if (tgt_run !== ~t0) begin bad++; $display("FAIL rd_issue got=%b want=%b", tgt_run, ~t0); end
    total++; if (tgt_addr !== 16'h2000 || tgt_cmd !== RD_W) begin bad++; $display("FAIL rd_fields got=%h/%h want=2000/%h", tgt_addr, tgt_cmd, RD_W); end
    total++; if (grant !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL rd_grant got=%0d/%b want=0/1", grant, busy); end
    @(negedge clk);
    total++; if (req_done !== d0) begin bad++; $display("FAIL rd_early got=%b want=%b", req_done, d0); end
    @(negedge clk);
    total++; if (req_done[0] !== ~d0[0]) begin bad++; $display("FAIL rd_done got=%b want=%b", req_done[0], ~d0[0]); end
    total++; if (req_rd_data[0 +: DW] !== 16'h1234) begin bad++; $display("FAIL rd_data got=%h want=1234", req_rd_data[0 +: DW]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy got=%b want=0", busy); end
  endtask

  task automatic test_single_write();
    logic [NREQ-1:0] d0;
    bit ok;
    @(negedge clk); #1;
    d0 = req_done;
    issue(1, 16'h2001, WR_B, 16'h00AB);
    @(negedge clk);
    total++; if (tgt_wr_data !== 16'h00AB || tgt_cmd !== WR_B || tgt_addr !== 16'h2001) begin bad++; $display("FAIL wr_fields got=%h/%h/%h want=2001/%h/00ab", tgt_addr, tgt_cmd, tgt_wr_data, WR_B); end
    total++; if (grant !== 2'd1) begin bad++; $display("FAIL wr_grant got=%0d want=1", grant); end
    wait_port(1, 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_done got=timeout want=done"); end
    total++; if (req_done[0] !== d0[0]) begin bad++; $display("FAIL wr_other_done got=%b want=%b", req_done[0], d0[0]); end
    total++; if (req_rd_data[DW +: DW] !== (16'h2001 ^ resp_key)) begin bad++; $display("FAIL wr_rd got=%h want=%h", req_rd_data[DW +: DW], 16'h2001 ^ resp_key); end
    total++; if (req_rd_data[0 +: DW] !== 16'h1234) begin bad++; $display("FAIL wr_other_rd got=%h want=1234", req_rd_data[0 +: DW]); end
  endtask

  task automatic test_contention();
    int seq[$];
    logic [AW-1:0] a [NREQ];
    logic [NREQ-1:0] pd;
    int served;
    bit ok;
    served = 0;
    @(negedge clk); #1;
    resp_key = 16'h0F0F;
    tgt_lat  = 0;
    for (int p = 0; p < NREQ; p++) begin
      a[p] = 16'(16'h0100 * (p + 1));
      issue(p, a[p], RD_W, 16'h0);
    end
    pd = req_done;
    for (int n = 0; n < 100 && served < 6; n++) begin
      @(negedge clk);
      for (int p = 0; p < NREQ; p++) begin
        if (req_done[p] != pd[p]) begin
          seq.push_back(p);
          served++;
          total++; if (req_rd_data[p*DW +: DW] !== (a[p] ^ resp_key)) begin bad++; $display("FAIL cont_data p=%0d got=%h want=%h", p, req_rd_data[p*DW +: DW], a[p] ^ resp_key); end
        end
      end
      pd = req_done;
      #1;
      for (int p = 0; p < NREQ; p++) begin
        if (req_done[p] == req_run[p] && served < 6) begin
          a[p] = a[p] + 16'd1;
          issue(p, a[p], RD_W, 16'h0);
        end
      end
    end
    total++; if (served != 6) begin bad++; $display("FAIL cont_count got=%0d want=6", served); end
    foreach (seq[i]) begin
      total++; if (seq[i] != i % 2) begin bad++; $display("FAIL cont_order idx=%0d got=%0d want=%0d", i, seq[i], i % 2); end
    end
    wait_all(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL cont_drain got=timeout want=idle"); end
  endtask

  task automatic test_stability();
    bit ok;
    @(negedge clk); #1;
    resp_key = 16'h1111;
    tgt_lat  = 3;
    issue(0, 16'h0010, RD_W, 16'h0);
    @(negedge clk);
    total++; if (grant !== 2'd0 || tgt_addr !== 16'h0010) begin bad++; $display("FAIL stab_grant got=%0d/%h want=0/0010", grant, tgt_addr); end
    #1 req_addr[0 +: AW] = 16'h0020;
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(negedge clk);
      total++; if (tgt_addr !== 16'h0010) begin bad++; $display("FAIL stab_addr got=%h want=0010", tgt_addr); end
      if (req_done[0] == req_run[0]) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL stab_done got=timeout want=done"); end
    total++; if (req_rd_data[0 +: DW] !== (16'h0010 ^ resp_key)) begin bad++; $display("FAIL stab_rd got=%h want=%h", req_rd_data[0 +: DW], 16'h0010 ^ resp_key); end
    tgt_lat = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(negedge clk); #1;
    tgt_lat = 3;
    issue(1, 16'h0777, RD_W, 16'h0);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
    @(negedge clk);
    #2;
    reset   = 1'b1;
    req_run = '0;
    #1;
    total++; if ({req_done, tgt_run, grant, busy} !== '0) begin bad++; $display("FAIL mid_reset got=%b want=0", {req_done, tgt_run, grant, busy}); end
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (req_done !== '0 || busy !== 1'b0) begin bad++; $display("FAIL mid_no_done got=%b/%b want=0/0", req_done, busy); end
    #1;
    tgt_lat  = 0;
    resp_key = 16'h5A5A;
    issue(1, 16'h3000, RD_W, 16'h0);
    @(negedge clk);
    total++; if (grant !== 2'd1 || tgt_addr !== 16'h3000) begin bad++; $display("FAIL mid_regrant got=%0d/%h want=1/3000", grant, tgt_addr); end
    wait_port(1, 10, ok);
    total++; if (!ok || req_rd_data[DW +: DW] !== (16'h3000 ^ resp_key)) begin bad++; $display("FAIL mid_after got=%b/%h want=1/%h", ok, req_rd_data[DW +: DW], 16'h3000 ^ resp_key); end
  endtask

  // Reference: idle with anything pending must issue the first pending port after the last
  // served one; busy must complete on the edge after the target toggles back.
  task automatic test_random(input int cycles);
    int m_last, mg, w, n_cmp;
    bit m_busy, cmp_now, ok;
    logic [NREQ-1:0] s_run, s_done, pend, exp_done;
    logic s_trun, s_tdone;
    logic [DW-1:0] s_trd;
    logic [NREQ*AW-1:0] s_addr;
    logic [NREQ*CW-1:0] s_cmd;
    logic [NREQ*DW-1:0] s_wd, s_rd;
    do_reset();
    m_last = NREQ - 1;
    mg = 0;
    m_busy = 1'b0;
    n_cmp = 0;
    resp_key = 16'($urandom);
    @(negedge clk); #1;
    for (int c = 0; c < cycles; c++) begin
      for (int p = 0; p < NREQ; p++)
        if (req_run[p] == req_done[p] && $urandom_range(0, 2) == 0)
          issue(p, 16'($urandom), 3'($urandom_range(0, 3)), 16'($urandom));
      tgt_lat = $urandom_range(0, 2);
      s_run = req_run; s_done = req_done; s_trun = tgt_run; s_tdone = tgt_done;
      s_trd = tgt_rd_data; s_addr = req_addr; s_cmd = req_cmd; s_wd = req_wr_data; s_rd = req_rd_data;
      pend = s_run ^ s_done;
      cmp_now = 1'b0;
      @(negedge clk);
      if (m_busy) begin
        if (s_trun == s_tdone) begin
          exp_done = s_done;
          exp_done[mg] = ~exp_done[mg];
          total++; if (req_done !== exp_done) begin bad++; $display("FAIL rnd_done c=%0d got=%b want=%b", c, req_done, exp_done); end
          total++; if (req_rd_data[mg*DW +: DW] !== s_trd) begin bad++; $display("FAIL rnd_rd c=%0d got=%h want=%h", c, req_rd_data[mg*DW +: DW], s_trd); end
          m_last = mg; m_busy = 1'b0; cmp_now = 1'b1; n_cmp++;
        end else begin
          total++; if (req_done !== s_done) begin bad++; $display("FAIL rnd_early c=%0d got=%b want=%b", c, req_done, s_done); end
        end
        total++; if (tgt_run !== s_trun) begin bad++; $display("FAIL rnd_reissue c=%0d got=%b want=%b", c, tgt_run, s_trun); end
      end else begin
        w = -1;
        for (int k = 1; k <= NREQ && w < 0; k++)
          if (pend[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
        total++; if (req_done !== s_done) begin bad++; $display("FAIL rnd_idle_done c=%0d got=%b want=%b", c, req_done, s_done); end
        if (w >= 0) begin
          total++; if (tgt_run !== ~s_trun) begin bad++; $display("FAIL rnd_issue c=%0d got=%b want=%b", c, tgt_run, ~s_trun); end
          total++; if (grant !== 2'(w)) begin bad++; $display("FAIL rnd_grant c=%0d got=%0d want=%0d", c, grant, w); end
          total++; if ({tgt_addr, tgt_cmd, tgt_wr_data} !== {s_addr[w*AW +: AW], s_cmd[w*CW +: CW], s_wd[w*DW +: DW]}) begin
            bad++; $display("FAIL rnd_fields c=%0d got=%h want=%h", c, {tgt_addr, tgt_cmd, tgt_wr_data}, {s_addr[w*AW +: AW], s_cmd[w*CW +: CW], s_wd[w*DW +: DW]});
          end
          mg = w; m_busy = 1'b1;
        end else begin
          total++; if (tgt_run !== s_trun) begin bad++; $display("FAIL rnd_spurious c=%0d got=%b want=%b", c, tgt_run, s_trun); end
        end
      end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy, m_busy); end
      total++; if (grant !== 2'(mg)) begin bad++; $display("FAIL rnd_grant_hold c=%0d got=%0d want=%0d", c, grant, mg); end
      for (int p = 0; p < NREQ; p++) begin
        if (!(cmp_now && p == mg)) begin
          total++; if (req_rd_data[p*DW +: DW] !== s_rd[p*DW +: DW]) begin bad++; $display("FAIL rnd_rd_hold c=%0d p=%0d got=%h want=%h", c, p, req_rd_data[p*DW +: DW], s_rd[p*DW +: DW]); end
        end
      end
      #1;
    end
    total++; if (n_cmp < 50) begin bad++; $display("FAIL rnd_activity got=%0d want>=50", n_cmp); end
    wait_all(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL rnd_drain got=timeout want=idle"); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_stability();
    test_reset_mid();
    test_random(800);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
